// File: rtl/keccak_pad_packer_pkg.sv
// Shared constants and types for the keccak message packer: command bit
// positions, SHA3 rate sizes, padding bytes and packer states.
package keccak_pad_packer_pkg;

  localparam int unsigned OP_HEAD = 2;
  localparam int unsigned OP_DATA = 1;
  localparam int unsigned OP_TAIL = 0;

  localparam int unsigned RATE_WORDS_224 = 36;
  localparam int unsigned RATE_WORDS_256 = 34;
  localparam int unsigned RATE_WORDS_384 = 26;
  localparam int unsigned RATE_WORDS_512 = 18;

  localparam logic [7:0] DSBYTE_SHA3 = 8'h06;
  localparam logic [7:0] PADEND      = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT
  } state_e;

  // CPU words carry the first message byte in [31:24]; the block wants it lowest.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/keccak_pad_packer_mask.sv
// Tail-word byte-keep mask and SHA3 pad-byte vector for the block buffer.
module keccak_pad_packer_mask
  import keccak_pad_packer_pkg::*;
#(
  parameter int unsigned RATE_WORDS = RATE_WORDS_512,
  parameter logic [7:0]  DSBYTE     = DSBYTE_SHA3,
  parameter int unsigned IDXW       = 5
) (
  input  logic [IDXW-1:0]          word_idx_i,
  input  logic [1:0]               nbytes_i,
  output logic [4*RATE_WORDS-1:0]  keep_o,
  output logic [32*RATE_WORDS-1:0] pad_o
);

  localparam int unsigned NB = 4 * RATE_WORDS;

  logic [31:0] pad_pos;

  assign pad_pos = (32'(word_idx_i) << 2) + 32'(nbytes_i);

  always_comb begin
    keep_o = '0;
    pad_o  = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      keep_o[k] = (k < pad_pos);
      if (k == pad_pos) begin
        pad_o[8*k +: 8] = DSBYTE;
      end
    end
    // Last rate byte always carries the closing 0x80, merged with DSBYTE if coincident.
    pad_o[8*(NB-1) +: 8] = pad_o[8*(NB-1) +: 8] | PADEND;
  end

endmodule

// File: rtl/keccak_pad_packer.sv
// Packs HEAD/DATA/TAIL message words into a rate block, applies SHA3 padding
// and hands complete blocks to the permutation over a valid/ready handshake.
module keccak_pad_packer
  import keccak_pad_packer_pkg::*;
#(
  parameter int unsigned RATE_WORDS = RATE_WORDS_512,
  parameter logic [7:0]  DSBYTE     = DSBYTE_SHA3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               in_op,
  input  logic [31:0]              in_word,
  input  logic [1:0]               in_nbytes,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*RATE_WORDS-1:0] out_block,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     err
);

  localparam int unsigned NB   = 4 * RATE_WORDS;
  localparam int unsigned BW   = 8 * NB;
  localparam int unsigned IDXW = $clog2(RATE_WORDS + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [IDXW-1:0] word_idx_q, word_idx_d;
  logic            first_q, first_d;
  logic            out_valid_q, out_valid_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;

  logic op_head, op_data, op_tail, op_illegal, cmd;

  logic [IDXW-1:0] mask_idx;
  logic [NB-1:0]   keep;
  logic [BW-1:0]   pad_vec;
  logic [BW-1:0]   keep_bits;
  logic [BW-1:0]   head_buf;
  logic [BW-1:0]   wr_buf;
  logic [BW-1:0]   tail_base;
  logic [BW-1:0]   tail_buf;

  assign op_head    = in_op[OP_HEAD];
  assign op_data    = in_op[OP_DATA];
  assign op_tail    = in_op[OP_TAIL];
  assign op_illegal = (in_op == 3'b000) | (op_data & (op_head | op_tail));
  assign cmd        = in_valid & ~out_valid_q;

  // HEAD|TAIL pads relative to a freshly cleared buffer, so index 0.
  assign mask_idx = op_head ? '0 : word_idx_q;

  keccak_pad_packer_mask #(
    .RATE_WORDS (RATE_WORDS),
    .DSBYTE     (DSBYTE),
    .IDXW       (IDXW)
  ) u_mask (
    .word_idx_i (mask_idx),
    .nbytes_i   (in_nbytes),
    .keep_o     (keep),
    .pad_o      (pad_vec)
  );

  always_comb begin
    head_buf       = '0;
    head_buf[31:0] = bswap32(in_word);
    wr_buf         = buf_q;
    for (int unsigned w = 0; w < RATE_WORDS; w++) begin
      if (IDXW'(w) == word_idx_q) begin
        wr_buf[32*w +: 32] = bswap32(in_word);
      end
    end
  end

  always_comb begin
    keep_bits = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      keep_bits[8*k +: 8] = {8{keep[k]}};
    end
    tail_base = op_head ? head_buf : wr_buf;
    tail_buf  = (tail_base & keep_bits) | pad_vec;
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    word_idx_d  = word_idx_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    if (state_q == ST_EMIT) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        buf_d       = '0;
        word_idx_d  = '0;
        first_d     = 1'b0;
        state_d     = out_last_q ? ST_IDLE : ST_FILL;
      end
    end else if (cmd) begin
      if (op_illegal) begin
        err_d = 1'b1;
      end else if (op_head && op_tail) begin
        buf_d       = tail_buf;
        word_idx_d  = '0;
        first_d     = 1'b1;
        out_valid_d = 1'b1;
        out_first_d = 1'b1;
        out_last_d  = 1'b1;
        state_d     = ST_EMIT;
      end else if (op_head) begin
        buf_d      = head_buf;
        word_idx_d = IDXW'(1);
        first_d    = 1'b1;
        state_d    = ST_FILL;
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else if (op_data) begin
        buf_d      = wr_buf;
        word_idx_d = word_idx_q + IDXW'(1);
        if (word_idx_q == IDXW'(RATE_WORDS - 1)) begin
          out_valid_d = 1'b1;
          out_first_d = first_q;
          out_last_d  = 1'b0;
          state_d     = ST_EMIT;
        end
      end else begin
        buf_d       = tail_buf;
        out_valid_d = 1'b1;
        out_first_d = first_q;
        out_last_d  = 1'b1;
        state_d     = ST_EMIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      word_idx_q  <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      word_idx_q  <= word_idx_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = ~out_valid_q;
  assign out_valid = out_valid_q;
  assign out_block = buf_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keccak_pad_packer.sv
// Directed bench for keccak_pad_packer: byte-level message model checked every
// cycle, plus literal expectations from hand-worked messages.
module tb_keccak_pad_packer;

  localparam int unsigned RW = 18;
  localparam int unsigned NB = 4 * RW;
  localparam int unsigned BW = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [2:0]    in_op = 3'b000;
  logic [31:0]   in_word = '0;
  logic [1:0]    in_nbytes = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_block;
  logic          out_first;
  logic          out_last;
  logic          err;

  keccak_pad_packer #(
    .RATE_WORDS (RW),
    .DSBYTE     (8'h06)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_nbytes (in_nbytes),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: message bytes in arrival order; a block is those bytes followed by padding.
  byte unsigned cur[$];
  bit [7:0] m_blk [NB];
  bit m_valid, m_first, m_last, m_err, m_active, m_ff;

  function automatic void model_reset();
    cur.delete();
    for (int k = 0; k < NB; k++) m_blk[k] = 8'h00;
    m_valid = 0; m_first = 0; m_last = 0; m_err = 0; m_active = 0; m_ff = 0;
  endfunction

  function automatic void push_bytes(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) cur.push_back(w[31-8*i -: 8]);
  endfunction

  function automatic void emit(input bit last);
    for (int k = 0; k < NB; k++) m_blk[k] = (k < cur.size()) ? cur[k] : 8'h00;
    if (last) begin
      m_blk[cur.size()] = m_blk[cur.size()] | 8'h06;
      m_blk[NB-1]       = m_blk[NB-1] | 8'h80;
      m_active = 0;
    end
    m_valid = 1; m_first = m_ff; m_last = last; m_ff = 0;
    cur.delete();
  endfunction

  function automatic void model_step();
    m_err = 0;
    if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      case (in_op)
        3'b100: begin cur.delete(); push_bytes(in_word, 4); m_active = 1; m_ff = 1; end
        3'b101: begin cur.delete(); push_bytes(in_word, int'(in_nbytes)); m_ff = 1; emit(1); end
        3'b010: begin
          if (!m_active) m_err = 1;
          else begin
            push_bytes(in_word, 4);
            if (cur.size() == NB) emit(0);
          end
        end
        3'b001: begin
          if (!m_active) m_err = 1;
          else begin push_bytes(in_word, int'(in_nbytes)); emit(1); end
        end
        default: m_err = 1;
      endcase
    end
  endfunction

  function automatic logic [BW-1:0] model_block();
    logic [BW-1:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = m_blk[k];
    return v;
  endfunction

  always @(negedge clk) begin : compare
    if (chk_en && rst) begin
      chk("out_valid", BW'(out_valid), BW'(m_valid));
      chk("in_ready", BW'(in_ready), BW'(!m_valid));
      chk("err", BW'(err), BW'(m_err));
      if (m_valid) begin
        chk("out_block", out_block, model_block());
        chk("out_first", BW'(out_first), BW'(m_first));
        chk("out_last", BW'(out_last), BW'(m_last));
      end
    end
  end

  function automatic logic [7:0] dbyte(input int k);
    return out_block[8*k +: 8];
  endfunction

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    chk(name, BW'(got), BW'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] w, input logic [1:0] nb);
    in_valid = 1'b1; in_op = op; in_word = w; in_nbytes = nb;
    tick();
    in_valid = 1'b0; in_op = 3'b000; in_word = '0; in_nbytes = '0;
  endtask

  function automatic logic [31:0] pat_word(input int i);
    return {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    string fox;
    logic [31:0] w;
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    tick();
    lit("reset_out_valid", 8'(out_valid), 8'h00);
    lit("reset_in_ready", 8'(in_ready), 8'h01);
    lit("reset_flags", {5'b0, out_first, out_last, err}, 8'h00);

    // "abc" in a single HEAD|TAIL
    send(3'b101, 32'h61626300, 2'd3);
    lit("abc_b0", dbyte(0), 8'h61);
    lit("abc_b1", dbyte(1), 8'h62);
    lit("abc_b2", dbyte(2), 8'h63);
    lit("abc_b3", dbyte(3), 8'h06);
    lit("abc_b4", dbyte(4), 8'h00);
    lit("abc_b71", dbyte(71), 8'h80);
    lit("abc_flags", {6'b0, out_first, out_last}, 8'h03);
    tick();

    // 44-byte pangram: HEAD + 10 DATA + TAIL nbytes=0
    fox = "The quick brown fox jumps over the lazy dog.";
    for (int i = 0; i < 11; i++) begin
      w = {fox[4*i], fox[4*i+1], fox[4*i+2], fox[4*i+3]};
      send((i == 0) ? 3'b100 : 3'b010, w, 2'd0);
    end
    send(3'b001, 32'h0, 2'd0);
    lit("fox_b0", dbyte(0), 8'h54);
    lit("fox_b43", dbyte(43), 8'h2E);
    lit("fox_b44", dbyte(44), 8'h06);
    lit("fox_b71", dbyte(71), 8'h80);
    lit("fox_flags", {6'b0, out_first, out_last}, 8'h03);
    tick();

    // 72-byte message: full block emitted on the 17th DATA, stalled 3 cycles
    send(3'b100, pat_word(0), 2'd0);
    for (int i = 1; i < 17; i++) send(3'b010, pat_word(i), 2'd0);
    out_ready = 1'b0;
    send(3'b010, pat_word(17), 2'd0);
    for (int s = 0; s < 3; s++) begin
      send(3'b010, 32'hDEADBEEF, 2'd0);
      lit("stall_valid", 8'(out_valid), 8'h01);
      lit("stall_ready", 8'(in_ready), 8'h00);
    end
    lit("b72_b0", dbyte(0), 8'h01);
    lit("b72_b71", dbyte(71), 8'h48);
    lit("b72_flags", {6'b0, out_first, out_last}, 8'h02);
    out_ready = 1'b1;
    tick();
    send(3'b001, 32'h0, 2'd0);
    lit("pad_b0", dbyte(0), 8'h06);
    lit("pad_b71", dbyte(71), 8'h80);
    lit("pad_flags", {6'b0, out_first, out_last}, 8'h01);
    tick();

    // 71-byte message: pad collides with the closing byte
    send(3'b100, pat_word(0), 2'd0);
    for (int i = 1; i < 17; i++) send(3'b010, pat_word(i), 2'd0);
    send(3'b001, 32'hAABBCC11, 2'd3);
    lit("b71_b68", dbyte(68), 8'hAA);
    lit("b71_b70", dbyte(70), 8'hCC);
    lit("b71_b71", dbyte(71), 8'h86);
    tick();

    // partial tail of two bytes after one full word
    send(3'b100, 32'h11223344, 2'd0);
    send(3'b001, 32'hAABBCCDD, 2'd2);
    lit("t2_b5", dbyte(5), 8'hBB);
    lit("t2_b6", dbyte(6), 8'h06);
    lit("t2_b7", dbyte(7), 8'h00);
    tick();

    // DATA / TAIL in IDLE flag an error
    send(3'b010, 32'h12345678, 2'd0);
    lit("idle_data_err", 8'(err), 8'h01);
    lit("idle_data_valid", 8'(out_valid), 8'h00);
    tick();
    lit("err_pulse_end", 8'(err), 8'h00);
    send(3'b001, 32'h0, 2'd1);

    // illegal opcodes mid-FILL, HEAD restart, then HEAD|TAIL restart
    send(3'b100, 32'hCAFEF00D, 2'd0);
    send(3'b011, 32'h0, 2'd0);
    lit("ill_011_err", 8'(err), 8'h01);
    send(3'b110, 32'h0, 2'd0);
    send(3'b111, 32'h0, 2'd0);
    in_valid = 1'b1; in_op = 3'b000; tick(); in_valid = 1'b0;
    lit("ill_000_err", 8'(err), 8'h01);
    send(3'b010, 32'h01020304, 2'd0);
    send(3'b100, 32'h55667788, 2'd0);
    send(3'b101, 32'h78000000, 2'd1);
    lit("rs_b0", dbyte(0), 8'h78);
    lit("rs_b1", dbyte(1), 8'h06);
    lit("rs_b71", dbyte(71), 8'h80);
    lit("rs_first", 8'(out_first), 8'h01);
    tick();

    // asynchronous reset in the middle of a message
    send(3'b100, pat_word(0), 2'd0);
    for (int i = 1; i < 5; i++) send(3'b010, pat_word(i), 2'd0);
    rst = 1'b0;
    model_reset();
    #1;
    lit("rst_valid", 8'(out_valid), 8'h00);
    tick();
    rst = 1'b1;
    tick();
    lit("rst_ready", 8'(in_ready), 8'h01);
    send(3'b010, 32'h0, 2'd0);
    lit("rst_idle_err", 8'(err), 8'h01);
    send(3'b101, 32'h0, 2'd0);
    lit("rst_b0", dbyte(0), 8'h06);
    lit("rst_b71", dbyte(71), 8'h80);
    tick();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
